// File: rtl/amber48_uart_tx_fifo.sv
// rtl/amber48_uart_tx_fifo.sv - byte FIFO with registered valid/ready output stage for the UART TX path
// Optional LF -> CR LF expansion when AMBER48_UART_FIFO_CRLF_EN is defined.
module amber48_uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  input  logic [DATA_W-1:0]          in_data_i,
  output logic                       in_ready_o,
  output logic                       out_valid_o,
  output logic [DATA_W-1:0]          out_data_o,
  input  logic                       out_ready_i,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

`ifdef AMBER48_UART_FIFO_CRLF_EN
  localparam logic [DATA_W-1:0] CHAR_LF = DATA_W'(8'h0A);
  localparam logic [DATA_W-1:0] CHAR_CR = DATA_W'(8'h0D);
  typedef enum logic [1:0] {OUT_EMPTY = 2'd0, OUT_BYTE = 2'd1, OUT_CR = 2'd2} out_state_e;
`else
  typedef enum logic [1:0] {OUT_EMPTY = 2'd0, OUT_BYTE = 2'd1} out_state_e;
`endif

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              full, empty, push, pop;
  logic [DATA_W-1:0] head;
  out_state_e        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Pointer MSBs differ only when the write side has lapped the read side.
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push       = in_valid_i && !full;
  assign head       = mem[rd_ptr[AW-1:0]];
  assign in_ready_o = !full;
  assign level_o    = wr_ptr - rd_ptr;
  assign out_valid_o = (state_q != OUT_EMPTY);
  assign out_data_o = data_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    pop     = 1'b0;
    case (state_q)
      OUT_EMPTY: pop = !empty;
      OUT_BYTE: begin
        if (out_ready_i) begin
          pop = !empty;
          if (empty) state_d = OUT_EMPTY;
        end
      end
`ifdef AMBER48_UART_FIFO_CRLF_EN
      // CR has gone out; emit the deferred LF without touching storage.
      OUT_CR: begin
        if (out_ready_i) begin
          data_d  = CHAR_LF;
          state_d = OUT_BYTE;
        end
      end
`endif
      default: state_d = OUT_EMPTY;
    endcase
    if (pop) begin
      data_d  = head;
      state_d = OUT_BYTE;
`ifdef AMBER48_UART_FIFO_CRLF_EN
      if (head == CHAR_LF) begin
        data_d  = CHAR_CR;
        state_d = OUT_CR;
      end
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      state_q    <= OUT_EMPTY;
      data_q     <= '0;
      overflow_o <= 1'b0;
    end else if (flush_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      state_q    <= OUT_EMPTY;
      data_q     <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      state_q <= state_d;
      data_q  <= data_d;
      if (in_valid_i && full) overflow_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !flush_i) mem[wr_ptr[AW-1:0]] <= in_data_i;
  end

endmodule

// File: tb/tb_amber48_uart_tx_fifo.sv
// tb/tb_amber48_uart_tx_fifo.sv - scoreboard bench for amber48_uart_tx_fifo
module tb_amber48_uart_tx_fifo;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       flush_i;
  logic       in_valid_i;
  logic [7:0] in_data_i;
  logic       in_ready_o;
  logic       out_valid_o;
  logic [7:0] out_data_o;
  logic       out_ready_i;
  logic [4:0] level_o;
  logic       overflow_o;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [7:0] sb[$];

  amber48_uart_tx_fifo #(.DEPTH(16), .DATA_W(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_ready_i(out_ready_i),
    .level_o(level_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Scoreboard: what will transfer on the coming edge is decided at the negedge.
  always @(negedge clk_i) begin
    logic [31:0] exp;
    if (!rst_ni || flush_i) begin
      sb.delete();
    end else begin
      if (out_valid_o && out_ready_i) begin
        exp = (sb.size() > 0) ? {24'h0, sb.pop_front()} : 32'hDEAD_BEEF;
        check("out_data", {24'h0, out_data_o}, exp);
      end
      if (in_valid_i && in_ready_o) begin
`ifdef AMBER48_UART_FIFO_CRLF_EN
        if (in_data_i == 8'h0A) sb.push_back(8'h0D);
`endif
        sb.push_back(in_data_i);
      end
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_out_valid"}, out_valid_o, 0);
    check({tag, "_level"}, level_o, 0);
    check({tag, "_overflow"}, overflow_o, 0);
    check({tag, "_in_ready"}, in_ready_o, 1);
    check({tag, "_out_data"}, out_data_o, 0);
  endtask

  task automatic push_seq(input int first, input int count);
    for (int i = 0; i < count; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = 8'(first + i);
      tick();
    end
    in_valid_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
    repeat (2) tick();
    check_idle("reset");
    rst_ni = 1'b1;
    tick();

    // single byte latency and hold
    in_valid_i = 1'b1; in_data_i = 8'h41;
    tick();
    in_valid_i = 1'b0;
    check("single_level_n", level_o, 1);
    check("single_valid_n", out_valid_o, 0);
    tick();
    check("single_valid_n1", out_valid_o, 1);
    check("single_data_n1", out_data_o, 8'h41);
    check("single_level_n1", level_o, 0);
    repeat (3) tick();
    check("single_hold_valid", out_valid_o, 1);
    check("single_hold_data", out_data_o, 8'h41);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check("single_done_valid", out_valid_o, 0);

    // fill, overflow, drain; repeated to cross the pointer wrap
    for (int r = 0; r < 3; r++) begin
      push_seq(0, 17);
      check("fill_in_ready", in_ready_o, 0);
      check("fill_level", level_o, 16);
      check("fill_out_data", out_data_o, 8'h00);
      check("fill_out_valid", out_valid_o, 1);
      in_valid_i = 1'b1; in_data_i = 8'hFF;
      tick();
      in_valid_i = 1'b0;
      check("overflow_set", overflow_o, 1);
      check("overflow_level", level_o, 16);
      out_ready_i = 1'b1;
      repeat (17) tick();
      out_ready_i = 1'b0;
      check("drain_valid", out_valid_o, 0);
      check("drain_level", level_o, 0);
      check("drain_sb_empty", sb.size(), 0);
      check("overflow_sticky", overflow_o, 1);
    end

    // concurrent streaming
    out_ready_i = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = 8'(8'h30 + i);
      tick();
      check("stream_level", level_o, 1);
    end
    in_valid_i = 1'b0;
    repeat (3) tick();
    out_ready_i = 1'b0;
    check("stream_valid", out_valid_o, 0);
    check("stream_sb_empty", sb.size(), 0);

    // LF handling
    in_valid_i = 1'b1; in_data_i = 8'h48; tick();
    in_data_i = 8'h0A; tick();
    in_data_i = 8'h49; tick();
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    repeat (6) tick();
    out_ready_i = 1'b0;
    check("crlf_valid", out_valid_o, 0);
    check("crlf_sb_empty", sb.size(), 0);

    // flush mid-burst (overflow is still set from the fill phase)
    push_seq(8'h80, 6);
    check("pre_flush_level", level_o, 5);
    check("pre_flush_overflow", overflow_o, 1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check_idle("flush");
    check("flush_sb_empty", sb.size(), 0);

    // asynchronous reset mid-burst
    push_seq(8'h90, 6);
    check("pre_rst_valid", out_valid_o, 1);
    #1 rst_ni = 1'b0;
    #1 check_idle("async_rst");
    sb.delete();
    #1 rst_ni = 1'b1;
    tick();
    check_idle("post_rst");

    // recovery after reset
    in_valid_i = 1'b1; in_data_i = 8'h5A; tick();
    in_valid_i = 1'b0;
    tick();
    check("recover_data", out_data_o, 8'h5A);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check("recover_sb_empty", sb.size(), 0);
    check("recover_valid", out_valid_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/amber48_uart_tx_fifo.md
# amber48_uart_tx_fifo

Byte FIFO between the data-memory UART MMIO port and the UART transmitter. It absorbs bursts of bytes that software writes faster than the serial line drains them. It presents a valid/ready stream to the transmitter. It sits downstream of the data-memory block's `uart_tx_valid/data/ready` handshake and upstream of the UART TX serializer.

## Interface
- `DEPTH`, 16: storage entries; power of two, 2..256.
- `DATA_W`, 8: byte width.
- `clk_i`  in  1: core clock, rising edge.
- `rst_ni`  in  1: reset, asynchronous, active-low.
- `flush_i`  in  1: synchronous clear of storage, output stage and `overflow_o`.
- `in_valid_i`  in  1: byte offered by the data-memory MMIO port.
- `in_data_i`  in  DATA_W: offered byte.
- `in_ready_o`  out  1: storage not full.
- `out_valid_o`  out  1: output register holds a byte for the transmitter.
- `out_data_o`  out  DATA_W: byte to transmit.
- `out_ready_i`  in  1: transmitter accepts the byte.
- `level_o`  out  $clog2(DEPTH)+1: entries held in storage, excluding the output register.
- `overflow_o`  out  1: sticky; a byte was offered while full.

## Operation
- **Storage.** Circular buffer with write and read pointers of $clog2(DEPTH)+1 bits. The MSB distinguishes full from empty. Pointers wrap modulo 2·DEPTH.
- **Push.** Occurs when `in_valid_i && in_ready_o`. `in_ready_o = !full`.
  - A push is refused when full, even if a pop happens in the same cycle.
  - A refused offer sets `overflow_o`, and the byte is dropped.
- **Output stage.** States:
  - OUT_EMPTY: `out_valid_o=0`.
  - OUT_BYTE: holds a byte.
  - OUT_CR: holds 0x0D with an LF pending; exists only under the macro.
- **Load.** The output register loads from storage (a pop) when storage is non-empty and either:
  - the state is OUT_EMPTY, or
  - the state is OUT_BYTE and `out_ready_i` is high in that cycle.
- **Handshake.** A byte is transferred when `out_valid_o && out_ready_i`.
  - `out_data_o` and `out_valid_o` stay stable until that transfer.
- **No bypass.** A byte pushed into empty storage always passes through storage first.
- **Simultaneous push and pop.** `level_o` is unchanged.
- **Flush.** `flush_i` has priority over push and pop. It returns pointers, the state and `overflow_o` to their reset values.

## Timing
- **Reset values:** `in_ready_o=1`, `out_valid_o=0`, `out_data_o=0`, `level_o=0`, `overflow_o=0`, state OUT_EMPTY.
- **Latency.** A byte pushed at edge N gives `level_o=1` after N. It is loaded at edge N+1, so `out_valid_o=1` after N+1, and `level_o` returns to 0.
- **Throughput.** With `out_ready_i` held high and storage non-empty, one byte per cycle; the output register reloads on the same edge as the handshake.
- **Full.** `in_ready_o` drops the cycle after the DEPTH-th entry is written. The output register holds one extra byte, so DEPTH+1 bytes are buffered in total.
- **Reset mid-operation.** Buffered bytes are discarded immediately; the asynchronous assert forces all outputs to their reset values.

## Configuration
- **`AMBER48_UART_FIFO_CRLF_EN` defined:**
  - When the popped byte is 0x0A, the output register loads 0x0D and enters OUT_CR.
  - On the handshake in OUT_CR, the output register becomes 0x0A (state OUT_BYTE) without popping storage.
  - No storage load occurs in OUT_CR.
  - 0x0D bytes in the input pass through unchanged.
- **Macro undefined:** all bytes pass through unchanged, OUT_CR does not exist, and one byte out is produced per byte in.

## Test plan
- **Reset and single byte.** Reset, push 0x41 with `out_ready_i=0` → `out_valid_o=1`, `out_data_o=0x41` two edges after the push; `level_o` goes 1 then 0; the byte is held until `out_ready_i=1`.
- **Fill and overflow** (DEPTH=16). `out_ready_i=0`, push 0x00..0x10 (17 bytes) → `in_ready_o=0`, `level_o=16`, `out_data_o=0x00`. An 18th offer of 0xFF sets `overflow_o=1`.
- **Drain order and wrap.** Raise `out_ready_i` → bytes 0x00..0x10 appear in order on consecutive cycles, with `level_o` back to 0. Repeat three times to cross the pointer wrap.
- **Concurrent push/pop.** Steady `in_valid_i`/`out_ready_i` streaming of 0x30..0x6F → `level_o` stays constant, and no byte is lost or duplicated.
- **CRLF** (macro on). Push 0x48 0x0A 0x49 → output sequence is 0x48 0x0D 0x0A 0x49. With the macro off, the output is 0x48 0x0A 0x49.
- **Flush/reset mid-burst.** With 5 bytes buffered, pulse `flush_i` → next cycle `out_valid_o=0`, `level_o=0`, `overflow_o=0`. Repeat with `rst_ni` pulsed low between edges → outputs clear asynchronously.
